decode_disp_imm_sequencer: RTL



---
 rtl/decode_disp_imm_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_disp_imm_sequencer.sv
// Collects displacement / immediate / second-immediate bytes from the prefetch window over one or
// more cycles, then extends the fields and presents them over a valid/ready handshake.
module decode_disp_imm_sequencer #(
  parameter int unsigned WINDOW_BYTES = 8,
  parameter bit          IMM2_ENABLE  = 1'b1,
  localparam int unsigned COUNT_W     = $clog2(WINDOW_BYTES + 1)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [1:0]                i_disp_size,
  input  logic                      i_disp_sext,
  input  logic [1:0]                i_imm_size,
  input  logic                      i_imm_sext,
  input  logic [1:0]                i_imm2_size,
  input  logic [8*WINDOW_BYTES-1:0] i_queue_bytes,
  input  logic [COUNT_W-1:0]        i_queue_count,
  output logic [COUNT_W-1:0]        o_queue_consume,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [31:0]               o_displacement,
  output logic [31:0]               o_immediate,
  output logic [15:0]               o_immediate2,
  output logic [3:0]                o_bytes_consumed
);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  function automatic logic [3:0] field_len(input logic [1:0] size);
    case (size)
      2'b00:   return 4'd0;
      2'b01:   return 4'd1;
      2'b10:   return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] imm2_len(input logic [1:0] size);
    case (size)
      2'b00:   return 4'd0;
      2'b01:   return 4'd1;
      default: return 4'd2;
    endcase
  endfunction

  // Up to four bytes starting at byte offset off; bytes past the buffer end read as zero.
  function automatic logic [31:0] get_raw(input logic [79:0] b, input logic [3:0] off);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(off) + k < 10) r[8*k +: 8] = b[8*(int'(off) + k) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sext);
    case (size)
      2'b00:   return 32'h0;
      2'b01:   return {{24{sext & raw[7]}}, raw[7:0]};
      2'b10:   return {{16{sext & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  disp_size_q, disp_size_d, imm_size_q, imm_size_d, imm2_size_q, imm2_size_d;
  logic        disp_sext_q, disp_sext_d, imm_sext_q, imm_sext_d;
  logic [3:0]  need_q, need_d, collected_q, collected_d, bytes_q, bytes_d;
  logic [79:0] buf_q, buf_d, buf_app;
  logic [31:0] disp_q, disp_d, imm_q, imm_d;
  logic [15:0] imm2_q, imm2_d;
  logic [3:0]  remaining, take, need_in, d_len, i_len;
  logic [31:0] raw2;
  logic        accept;

  assign remaining = need_q - collected_q;
  assign take      = (int'(i_queue_count) < int'(remaining)) ? 4'(i_queue_count) : remaining;
  assign need_in   = field_len(i_disp_size) + field_len(i_imm_size)
                   + (IMM2_ENABLE ? imm2_len(i_imm2_size) : 4'd0);
  assign d_len     = field_len(disp_size_q);
  assign i_len     = field_len(imm_size_q);
  assign raw2      = get_raw(buf_app, d_len + i_len);

  assign o_req_ready     = (state_q == StIdle) && !i_reset && !i_flush;
  assign o_queue_consume = ((state_q == StFetch) && !i_reset && !i_flush) ? COUNT_W'(take) : '0;
  assign accept          = o_req_ready && i_req_valid;

  // Append window bytes 0..take-1 at offset collected.
  always_comb begin
    buf_app = buf_q;
    for (int i = 0; i < 10; i++) begin
      if (i >= int'(collected_q) && i < int'(collected_q) + int'(take) &&
          (i - int'(collected_q)) < int'(WINDOW_BYTES)) begin
        buf_app[8*i +: 8] = i_queue_bytes[8*(i - int'(collected_q)) +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    disp_size_d = disp_size_q;
    disp_sext_d = disp_sext_q;
    imm_size_d  = imm_size_q;
    imm_sext_d  = imm_sext_q;
    imm2_size_d = imm2_size_q;
    need_d      = need_q;
    collected_d = collected_q;
    buf_d       = buf_q;
    disp_d      = disp_q;
    imm_d       = imm_q;
    imm2_d      = imm2_q;
    bytes_d     = bytes_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          disp_size_d = i_disp_size;
          disp_sext_d = i_disp_sext;
          imm_size_d  = i_imm_size;
          imm_sext_d  = i_imm_sext;
          imm2_size_d = IMM2_ENABLE ? i_imm2_size : 2'b00;
          need_d      = need_in;
          collected_d = '0;
          buf_d       = '0;
          if (need_in == 4'd0) begin
            state_d = StDone;
            disp_d  = '0;
            imm_d   = '0;
            imm2_d  = '0;
            bytes_d = '0;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        buf_d       = buf_app;
        collected_d = collected_q + take;
        if (collected_q + take == need_q) begin
          state_d = StDone;
          disp_d  = extend(get_raw(buf_app, 4'd0), disp_size_q, disp_sext_q);
          imm_d   = extend(get_raw(buf_app, d_len), imm_size_q, imm_sext_q);
          case (imm2_size_q)
            2'b00:   imm2_d = 16'h0;
            2'b01:   imm2_d = {8'h0, raw2[7:0]};
            default: imm2_d = raw2[15:0];
          endcase
          bytes_d = need_q;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (i_flush) begin
      state_d     = StIdle;
      collected_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      disp_size_q <= '0;
      disp_sext_q <= 1'b0;
      imm_size_q  <= '0;
      imm_sext_q  <= 1'b0;
      imm2_size_q <= '0;
      need_q      <= '0;
      collected_q <= '0;
      buf_q       <= '0;
      disp_q      <= '0;
      imm_q       <= '0;
      imm2_q      <= '0;
      bytes_q     <= '0;
    end else begin
      state_q     <= state_d;
      disp_size_q <= disp_size_d;
      disp_sext_q <= disp_sext_d;
      imm_size_q  <= imm_size_d;
      imm_sext_q  <= imm_sext_d;
      imm2_size_q <= imm2_size_d;
      need_q      <= need_d;
      collected_q <= collected_d;
      buf_q       <= buf_d;
      disp_q      <= disp_d;
      imm_q       <= imm_d;
      imm2_q      <= imm2_d;
      bytes_q     <= bytes_d;
    end
  end

  assign o_valid          = (state_q == StDone);
  assign o_displacement   = disp_q;
  assign o_immediate      = imm_q;
  assign o_immediate2     = IMM2_ENABLE ? imm2_q : 16'h0;
  assign o_bytes_consumed = bytes_q;

endmodule
